// File: rtl/mux_arb.sv
// N-channel to one registered multiplexer/arbiter with a single-entry output stage.
// Fixed-select is always built; round-robin mode is compiled in only with MUX_ARB_RR_EN.
module mux_arb #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             load_en;
  logic             accept;
  logic             fix_vld;
  logic [SELW-1:0]  fix_idx;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new entry when empty or draining this cycle.
  assign load_en = !out_valid || out_ready;
  assign accept  = grant_vld && load_en;

  // A select value at or above NCH never matches a channel, so it yields no grant.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fix_vld = 1'b0;
    fix_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k) && in_valid[k]) begin
        fix_vld = 1'b1;
        fix_idx = SELW'(k);
      end
    end
  end

`ifdef MUX_ARB_RR_EN
  logic             rr_vld;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  last_grant;

  // Offset i is the search distance from last_grant; the first valid hit wins.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!rr_vld && in_valid[k] && last_grant == SELW'((k - i + NCH) % NCH)) begin
          rr_vld = 1'b1;
          rr_idx = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end else begin
      grant_vld = fix_vld;
      grant_idx = fix_idx;
    end
  end

  // Pointer moves only on an accepted transfer, regardless of which mode chose it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SELW'(NCH - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  assign grant_vld = fix_vld;
  assign grant_idx = fix_idx;
`endif

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_idx == SELW'(k)) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is withheld during reset so no producer believes a beat was taken.
  always_comb begin
    in_ready = '0;
    if (rst_n && accept) begin
      for (int k = 0; k < NCH; k++) begin
        if (grant_idx == SELW'(k)) begin
          in_ready[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));
`endif

endmodule
